// File: rtl/usb_dfu_page_sequencer.sv
// usb_dfu_page_sequencer
//
// Maps each DFU_DNLOAD / DFU_UPLOAD block onto one single-page transaction of
// usb_spiflash_bridge. The block number is range-checked against the image
// window. Bytes pass straight between the USB endpoint FIFOs and the bridge.
// busy/done/error are reported back to the DFU state machine.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   dnload_start, upload_start  one-cycle block start pulses (download wins)
//   block_num, block_len        wBlockNum / wLength, sampled on a start
//   out_data_avail/out_data/out_data_get   OUT endpoint FIFO (download bytes)
//   in_data_free/in_data_put/in_data       IN endpoint FIFO (upload bytes)
//   busy, done, error           status to the DFU state machine
//   address                     flash page to the bridge
//   rd_request, rd_data_free, rd_data_put, rd_data     bridge read side
//   wr_request, wr_busy, wr_data_avail, wr_data_get, wr_data   bridge write side
module usb_dfu_page_sequencer #(
  parameter int          PAGE_SIZE = 256,
  parameter logic [15:0] BASE_PAGE = 16'h0000,
  parameter logic [15:0] LAST_PAGE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dnload_start,
  input  logic        upload_start,
  input  logic [15:0] block_num,
  input  logic [15:0] block_len,
  input  logic        out_data_avail,
  input  logic [7:0]  out_data,
  output logic        out_data_get,
  input  logic        in_data_free,
  output logic        in_data_put,
  output logic [7:0]  in_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] address,
  output logic        rd_request,
  output logic        rd_data_free,
  input  logic        rd_data_put,
  input  logic [7:0]  rd_data,
  output logic        wr_request,
  input  logic        wr_busy,
  output logic        wr_data_avail,
  input  logic        wr_data_get,
  output logic [7:0]  wr_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_FILL   = 3'd1;
  localparam logic [2:0] S_WR_WAIT   = 3'd2;
  localparam logic [2:0] S_RD_STREAM = 3'd3;
  localparam logic [2:0] S_RD_END    = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]  state;
  logic [15:0] remaining;
  logic        seen_busy;

  logic [16:0] page_sum;
  logic        out_of_range;
  logic        too_long;
  logic        rem_nz;
  logic        in_wr_fill;
  logic        in_rd_stream;
  logic        wr_take;
  logic        rd_take;

  // 17-bit sum so a carry out of 16 bits also counts as out of range.
  assign page_sum     = {1'b0, BASE_PAGE} + {1'b0, block_num};
  assign out_of_range = page_sum > {1'b0, LAST_PAGE};
  assign too_long     = {16'd0, block_len} > 32'(PAGE_SIZE);

  assign rem_nz       = remaining != 16'd0;
  assign in_wr_fill   = state == S_WR_FILL;
  assign in_rd_stream = state == S_RD_STREAM;

  // Zero-latency pass-throughs, gated by state so everything idles at 0.
  assign wr_request    = in_wr_fill;
  assign wr_data_avail = in_wr_fill && out_data_avail && rem_nz;
  assign wr_data       = in_wr_fill ? out_data : 8'd0;
  assign out_data_get  = in_wr_fill && wr_data_get;

  // rd_data_free uses the registered count so it is already low the cycle
  // after the final put and the bridge cannot launch an extra byte.
  assign rd_request    = in_rd_stream;
  assign rd_data_free  = in_rd_stream && in_data_free && rem_nz;
  assign in_data_put   = in_rd_stream && rd_data_put;
  assign in_data       = in_rd_stream ? rd_data : 8'd0;

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;

  assign wr_take = in_wr_fill && wr_data_get && rem_nz;
  assign rd_take = in_rd_stream && rd_data_put && rem_nz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= 16'd0;
      seen_busy <= 1'b0;
      address   <= 16'd0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dnload_start || upload_start) begin
            address   <= page_sum[15:0];
            remaining <= block_len;
            seen_busy <= 1'b0;
            if (too_long || out_of_range) begin
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b0;
              if (block_len == 16'd0)
                state <= S_DONE;
              else if (dnload_start)
                state <= S_WR_FILL;
              else
                state <= S_RD_STREAM;
            end
          end
        end
        S_WR_FILL: begin
          if (wr_busy)
            seen_busy <= 1'b1;
          // Leaving on the last get drops wr_request on the following cycle.
          if (wr_take) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          // Busy must be seen before its fall counts as completion, so a
          // bridge slow to start erasing is not mistaken for finished.
          if (wr_busy)
            seen_busy <= 1'b1;
          else if (seen_busy)
            state <= S_DONE;
        end
        S_RD_STREAM: begin
          if (rd_take) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1)
              state <= S_RD_END;
          end
        end
        S_RD_END: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_dfu_page_sequencer.md
# usb_dfu_page_sequencer

- Sits between the DFU class request handler and `usb_spiflash_bridge`.
- Turns each DFU_DNLOAD or DFU_UPLOAD block into a single-page flash transaction on the bridge's page-address, request and byte-stream handshakes.
- Bounds-checks block numbers against the image window.
- Forwards bytes between the USB endpoint FIFOs and the bridge.
- Reports busy/done/error back to the DFU state machine for dfuDNBUSY and dfuUPLOAD handling.

## Interface
Parameters:
- PAGE_SIZE, 256: bytes per flash page; the maximum block length.
- BASE_PAGE, 16'h0000: flash page that DFU block 0 maps to.
- LAST_PAGE, 16'hFFFF: highest flash page writable or readable.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- dnload_start  in  1  one-cycle pulse that starts a download block.
- upload_start  in  1  one-cycle pulse that starts an upload block.
- block_num  in  16  DFU wBlockNum, sampled on a start pulse.
- block_len  in  16  DFU wLength in bytes, sampled on a start pulse.
- out_data_avail  in  1  OUT FIFO has a byte.
- out_data  in  8  OUT FIFO byte.
- out_data_get  out  1  OUT FIFO pop.
- in_data_free  in  1  IN FIFO has space.
- in_data_put  out  1  IN FIFO push.
- in_data  out  8  IN FIFO byte.
- busy  out  1  block in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  last block was rejected; held until the next start.
- address  out  16  flash page address to the bridge.
- rd_request  out  1  to bridge.
- rd_data_free  out  1  to bridge.
- rd_data_put  in  1  from bridge.
- rd_data  in  8  from bridge.
- wr_request  out  1  to bridge.
- wr_busy  in  1  from bridge.
- wr_data_avail  out  1  to bridge.
- wr_data_get  in  1  from bridge.
- wr_data  out  8  to bridge.

## Operation
States: IDLE, WR_FILL, WR_WAIT, RD_STREAM, RD_END, DONE.

- **IDLE, sampling a start:**
  - page = BASE_PAGE + block_num, computed 17 bits wide. The page is out of range if the sum exceeds LAST_PAGE or carries out of 16 bits.
  - remaining = block_len.
  - block_len > PAGE_SIZE or page out of range: go to DONE with error=1. No bridge request is made.
  - block_len == 0: go to DONE with error=0. No flash access; this is the DFU manifest and zero-length upload case.
  - dnload_start has priority over upload_start if both arrive together.
- **Start pulses:** ignored unless in IDLE.
- **address:** registered page; held stable from the start cycle until IDLE is re-entered.
- **WR_FILL:**
  - wr_request=1.
  - wr_data_avail = out_data_avail && remaining≠0.
  - wr_data = out_data; out_data_get = wr_data_get.
  - remaining decrements on each wr_data_get.
  - A seen_busy flag sets on any cycle with wr_busy=1 while wr_request=1.
  - When remaining reaches 0: drop wr_request on the next cycle and go to WR_WAIT.
- **WR_WAIT:**
  - wr_request=0.
  - Sets seen_busy if wr_busy=1.
  - Exits to DONE once seen_busy=1 and wr_busy=0. This covers erase, program and status-poll completion.
- **RD_STREAM:**
  - rd_request=1.
  - rd_data_free = in_data_free && remaining≠0.
  - in_data_put = rd_data_put; in_data = rd_data.
  - remaining decrements on rd_data_put.
  - At remaining=0, go to RD_END.
- **RD_END:** rd_request=0 for one cycle so the bridge returns to idle, then go to DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **busy:** busy=1 in every state except IDLE.
- **error:** cleared on any accepted start; set only on rejection.
- **remaining:** 16 bits; it never underflows because enables are gated on remaining≠0.

## Timing
- **Reset values:** all outputs 0, address=0, state IDLE. Reset asserted mid-transfer aborts immediately with the same values; the bridge is reset by the same signal.
- **Start pulse:** busy rises the cycle after the start pulse, and wr_request or rd_request rises on that same cycle.
- **Rejected block:** busy high for 1 cycle (DONE), done on that cycle; 2 cycles from start to done.
- **Write:** done is asserted 1 cycle after wr_busy is seen low with seen_busy set.
- **Read:** done follows the last in_data_put by 2 cycles (RD_END, then DONE).
- **Handshakes:** out_data_get, wr_data, in_data_put and in_data are combinational pass-throughs. No buffering; zero added latency.
- **Read byte launch:** the bridge launches a byte only after a put cycle. rd_data_free must be computed from the registered remaining so it is already 0 the cycle after the final put.

## Test plan
1. dnload_start, block_num=3, block_len=256, BASE_PAGE=16'h0028, OUT FIFO always available -> address=16'h002B, exactly 256 wr_data_get with matching bytes, wr_request falls after the 256th, done once after wr_busy falls, error=0.
2. dnload_start, block_len=300 -> no wr_request, done on cycle 2, error=1. Next valid start clears error.
3. upload_start, block_num=0, block_len=64, in_data_free toggling every 3 cycles -> exactly 64 in_data_put carrying rd_data values, rd_data_free never high when remaining=0, rd_request low 1 cycle before done.
4. dnload_start, block_len=0 -> done on cycle 2, error=0, no bridge activity.
5. block_num with BASE_PAGE+block_num = 16'h10000, or a page above LAST_PAGE=16'h00FF -> error=1, no request.
6. Reset asserted mid-WR_FILL after 10 bytes -> all outputs 0 asynchronously. A subsequent dnload_start completes normally; a start pulse during busy is ignored.
